immediate_decoder: RTL and testbench
====================================

IMMEDIATE_DECODER -- requirements
Module: immediate_decoder

Interface
REQ-001 Parameter: XLEN, default 64, immediate output width; SHALL be >= 32.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: instruction  input  32  RISC-V instruction word to decode.
REQ-005 Port: immediate  output  XLEN  sign-extended immediate, two's complement.
REQ-006 Port: imm_fmt  output  3  decoded format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-007 Port: imm_valid  output  1  high when imm_fmt != NONE.

Function
REQ-008 Opcode is instruction[6:0]; the format is selected from the opcode alone.
REQ-009 I format for opcodes 0000011 (load), 0010011 (OP-IMM), 0011011 (OP-IMM-32) and 1100111 (JALR): imm = sext(inst[31:20]).
REQ-010 S format for opcode 0100011: imm = sext({inst[31:25], inst[11:7]}).
REQ-011 B format for opcode 1100011: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); bit 0 is always 0.
REQ-012 U format for opcodes 0110111 (LUI) and 0010111 (AUIPC): imm = sext({inst[31:12], 12'b0}).
REQ-013 J format for opcode 1101111 (JAL): imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
REQ-014 Sign extension is from inst[31] in every format, up to XLEN bits.
REQ-015 All other opcodes, including R-type 0110011, SYSTEM and undefined codes, decode as NONE: immediate = 0, imm_fmt = 0, imm_valid = 0.
REQ-016 Shift-immediate instructions decode as raw I format; shamt and funct bits are not masked.
REQ-017 Decode logic is purely combinational from instruction; no dependence on any earlier instruction.
REQ-018 immediate, imm_fmt and imm_valid are registered on the rising edge of clk; latency is exactly 1 cycle from instruction to outputs.
REQ-019 A new instruction may be presented every cycle; throughput is 1 per cycle, with no handshake and no stall.
REQ-020 Outputs hold their value while instruction is stable.
REQ-021 Any X/undefined opcode bit decodes as NONE, so outputs are never X after reset.

Reset
REQ-022 While rst_n = 0, immediate = 0, imm_fmt = 0 and imm_valid = 0, applied immediately and independent of clk.
REQ-023 Reset asserted mid-stream discards the in-flight decode.
REQ-024 On rst_n deassertion, the first decoded value appears after the first subsequent rising edge of clk.

Structure
REQ-025 A shared package holds the opcode constants (LOAD, OP_IMM, OP_IMM_32, JALR, STORE, BRANCH, LUI, AUIPC, JAL) and the 3-bit format enum.
REQ-026 The block is a single module with no sub-module: a combinational format classifier and immediate assembler, followed by one output register stage.

Verification
REQ-027 Branch: instruction = {1, 111111, 00000, 00000, 000, 0110, 1, 1100011} (beq, -20) -> after 1 clk: immediate = -20, imm_fmt = 3, imm_valid = 1.
REQ-028 Addi: {12'd50, 5'd4, 000, 5'd5, 0010011} -> immediate = 50, imm_fmt = 1; store {7'b0, 5'd4, 5'd0, 010, 10010, 0100011} -> immediate = 18, imm_fmt = 2.
REQ-029 Jumps: 32'b00111010010000000000000011101111 (JAL) -> immediate = 932, imm_fmt = 5; 32'b00000000100000000000000001100111 (JALR) -> immediate = 8, imm_fmt = 1.
REQ-030 U format: 32'b00000000000000000001001010010111 (AUIPC) -> immediate = 4096, imm_fmt = 4; 32'hFFFFF037 (LUI) -> immediate = 64'hFFFFFFFFFFFFF000.
REQ-031 NONE and sign extension: 32'h002081B3 (add) -> immediate = 0, imm_valid = 0; 32'hFFF00093 (addi -1) -> immediate = all ones.
REQ-032 Reset: assert rst_n = 0 between clock edges while outputs are nonzero -> all outputs are 0 immediately; after release, the next edge loads the decoded current instruction.

Source files
------------

// File: rtl/immediate_decoder_pkg.sv
// Shared opcode constants and immediate-format encoding for the RISC-V
// immediate decoder.
package immediate_decoder_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/immediate_decoder.sv
// RISC-V immediate decoder: classifies the opcode, assembles the sign-extended
// immediate and registers it with a single-cycle latency.
module immediate_decoder
  import immediate_decoder_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      imm_fmt,
  output logic            imm_valid
);

  if (XLEN < 32) begin : g_xlen_check
    $error("immediate_decoder: XLEN must be at least 32");
  end

  imm_fmt_e        fmt_d;
  logic [31:0]     imm32_d;
  logic [XLEN-1:0] immediate_d;
  logic            imm_valid_d;

  logic [XLEN-1:0] immediate_q;
  imm_fmt_e        imm_fmt_q;
  logic            imm_valid_q;

  // Unmatched or unknown opcodes fall to the default arm, so they yield NONE.
  always_comb begin
    fmt_d   = FMT_NONE;
    imm32_d = '0;
    case (instruction[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        fmt_d   = FMT_I;
        imm32_d = {{20{instruction[31]}}, instruction[31:20]};
      end
      OPC_STORE: begin
        fmt_d   = FMT_S;
        imm32_d = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        fmt_d   = FMT_B;
        imm32_d = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_d   = FMT_U;
        imm32_d = {instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_d   = FMT_J;
        imm32_d = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      default: begin
        fmt_d   = FMT_NONE;
        imm32_d = '0;
      end
    endcase
  end

  // imm32_d already carries inst[31] in its MSB, so a signed resize completes
  // the extension for any XLEN >= 32.
  assign immediate_d = XLEN'($signed(imm32_d));
  assign imm_valid_d = (fmt_d != FMT_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immediate_q <= '0;
      imm_fmt_q   <= FMT_NONE;
      imm_valid_q <= 1'b0;
    end else begin
      immediate_q <= immediate_d;
      imm_fmt_q   <= fmt_d;
      imm_valid_q <= imm_valid_d;
    end
  end

  assign immediate = immediate_q;
  assign imm_fmt   = imm_fmt_q;
  assign imm_valid = imm_valid_q;

endmodule

// File: tb/tb_immediate_decoder.sv
// Self-checking bench for immediate_decoder: directed vectors, reset behaviour
// and randomized instructions against an arithmetic reference model.
module tb_immediate_decoder;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic [31:0]     instruction;
  logic [XLEN-1:0] immediate;
  logic [2:0]      imm_fmt;
  logic            imm_valid;

  int total = 0;
  int bad   = 0;

  immediate_decoder #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .immediate   (immediate),
    .imm_fmt     (imm_fmt),
    .imm_valid   (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: value of the immediate as a plain signed integer built
  // from weighted instruction fields.
  function automatic void model(input logic [31:0] w, output longint imm, output int fmt);
    longint s;
    s = w[31] ? 64'sd1 : 64'sd0;
    imm = 0;
    fmt = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        fmt = 1;
        imm = longint'(w[31:20]) - s * 4096;
      end
      7'h23: begin
        fmt = 2;
        imm = longint'(w[31:25]) * 32 + longint'(w[11:7]) - s * 4096;
      end
      7'h63: begin
        fmt = 3;
        imm = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2 - s * 4096;
      end
      7'h37, 7'h17: begin
        fmt = 4;
        imm = longint'(w[31:12]) * 4096 - s * 64'sd4294967296;
      end
      7'h6F: begin
        fmt = 5;
        imm = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2 - s * 1048576;
      end
      default: begin
        fmt = 0;
        imm = 0;
      end
    endcase
  endfunction

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present an instruction at the falling edge and sample 1 ns after the
  // next rising edge, i.e. one cycle of latency.
  task automatic drive(input logic [31:0] w);
    @(negedge clk);
    instruction = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag, input logic [31:0] w);
    longint imm;
    int     fmt;
    model(w, imm, fmt);
    chk64({tag, ".imm"}, immediate, 64'(imm));
    chk3({tag, ".fmt"}, imm_fmt, 3'(fmt));
    chk1({tag, ".valid"}, imm_valid, fmt != 0);
  endtask

  task automatic directed(input string tag, input logic [31:0] w,
                          input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
    drive(w);
    chk64({tag, ".imm"}, immediate, exp_imm);
    chk3({tag, ".fmt"}, imm_fmt, exp_fmt);
    chk1({tag, ".valid"}, imm_valid, exp_fmt != 3'd0);
  endtask

  logic [6:0]  opc_list [10] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [31:0] w;
    rst_n       = 1'b0;
    instruction = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk64("reset.imm", immediate, 64'h0);
    chk3("reset.fmt", imm_fmt, 3'd0);
    chk1("reset.valid", imm_valid, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    directed("beq",   {1'b1, 6'b111111, 5'd0, 5'd0, 3'b000, 4'b0110, 1'b1, 7'b1100011},
             64'hFFFF_FFFF_FFFF_FFEC, 3'd3);
    directed("addi",  {12'd50, 5'd4, 3'b000, 5'd5, 7'b0010011}, 64'd50, 3'd1);
    directed("sw",    {7'b0, 5'd4, 5'd0, 3'b010, 5'b10010, 7'b0100011}, 64'd18, 3'd2);
    directed("jal",   32'b00111010010000000000000011101111, 64'd932, 3'd5);
    directed("jalr",  32'b00000000100000000000000001100111, 64'd8, 3'd1);
    directed("auipc", 32'b00000000000000000001001010010111, 64'd4096, 3'd4);
    directed("lui",   32'hFFFFF037, 64'hFFFF_FFFF_FFFF_F000, 3'd4);
    directed("add",   32'h002081B3, 64'h0, 3'd0);
    directed("addim1", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    directed("srai",  32'h40305013, 64'd1027, 3'd1);
    directed("ecall", 32'h00000073, 64'h0, 3'd0);
    directed("jalneg", 32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, 3'd5);

    // Stable instruction: outputs hold.
    drive(32'hFFF00093);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk64("hold.imm", immediate, 64'hFFFF_FFFF_FFFF_FFFF);
      chk3("hold.fmt", imm_fmt, 3'd1);
    end

    // Asynchronous reset between edges while outputs are nonzero.
    drive(32'hFFFFF037);
    #2;
    rst_n = 1'b0;
    #1;
    chk64("arst.imm", immediate, 64'h0);
    chk3("arst.fmt", imm_fmt, 3'd0);
    chk1("arst.valid", imm_valid, 1'b0);
    @(negedge clk);
    instruction = {12'd50, 5'd4, 3'b000, 5'd5, 7'b0010011};
    @(posedge clk);
    #1;
    chk64("arst_hold.imm", immediate, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk64("release_pre.imm", immediate, 64'h0);
    @(posedge clk);
    #1;
    chk64("release.imm", immediate, 64'd50);
    chk3("release.fmt", imm_fmt, 3'd1);
    chk1("release.valid", imm_valid, 1'b1);

    // In-flight decode discarded by a reset pulse that straddles an edge.
    @(negedge clk);
    instruction = 32'h00800067;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk64("discard.imm", immediate, 64'h0);
    chk1("discard.valid", imm_valid, 1'b0);

    // Randomized back-to-back stream.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = opc_list[$urandom_range(0, 9)];
      drive(w);
      check_model("rand", w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
